// File: rtl/branch_ctrl.sv
// Branch/launch controller: IDLE->LOAD->RUN->DONE sequencing, branch-target LUT, zero-latency branch outputs in RUN.
// Optional executed-cycle counter enabled by macro BRANCH_CTRL_CYCLE_COUNT_EN (tied to 0 when undefined).
module branch_ctrl #(
    parameter int INST_WIDTH = 9,
    parameter int LUT_DEPTH  = 16,
    parameter int PROG1_BASE = 128,
    parameter int PROG2_BASE = 256,
    localparam int IDX_W     = (LUT_DEPTH > 1) ? $clog2(LUT_DEPTH) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [1:0]            prog_sel,
    input  logic                  is_branch,
    input  logic                  branch_cond,
    input  logic [IDX_W-1:0]      lut_idx,
    input  logic                  lut_we,
    input  logic [IDX_W-1:0]      lut_waddr,
    input  logic [INST_WIDTH-1:0] lut_wdata,
    input  logic                  halt_in,
    output logic                  pc_reset,
    output logic                  ctrl_branch,
    output logic                  take_branch,
    output logic [INST_WIDTH-1:0] target_addr,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [15:0]           cycle_count
);

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t                state;
    logic [INST_WIDTH-1:0] start_addr;
    logic [INST_WIDTH-1:0] sel_base;
    logic [INST_WIDTH-1:0] lut [LUT_DEPTH];
    logic                  sel_ok;
    logic                  launch;
    logic                  rd_ok;
    logic                  wr_ok;
    logic                  in_run;

    assign sel_ok = (prog_sel != 2'd3);
    assign launch = start && sel_ok && (state == IDLE || state == DONE);
    assign in_run = (state == RUN);

    always_comb begin
        sel_base = '0;
        case (prog_sel)
            2'd1:    sel_base = INST_WIDTH'(PROG1_BASE);
            2'd2:    sel_base = INST_WIDTH'(PROG2_BASE);
            default: sel_base = '0;
        endcase
    end

    // Index range guards only matter when LUT_DEPTH is not a power of two.
    generate
        if (LUT_DEPTH == (2 ** IDX_W)) begin : g_full
            assign rd_ok = 1'b1;
            assign wr_ok = 1'b1;
        end else begin : g_part
            assign rd_ok = ({1'b0, lut_idx}   < (IDX_W + 1)'(LUT_DEPTH));
            assign wr_ok = ({1'b0, lut_waddr} < (IDX_W + 1)'(LUT_DEPTH));
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            start_addr <= '0;
            pc_reset   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
        end else begin
            pc_reset <= 1'b0;
            err      <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && sel_ok) begin
                        state      <= LOAD;
                        start_addr <= sel_base;
                        pc_reset   <= 1'b1;
                        busy       <= 1'b1;
                    end else if (start) begin
                        err <= 1'b1;
                    end
                end
                LOAD: state <= RUN;
                RUN: begin
                    if (halt_in) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    if (start && sel_ok) begin
                        state      <= LOAD;
                        start_addr <= sel_base;
                        pc_reset   <= 1'b1;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // LUT has no reset; writes are accepted only while no program is executing.
    always_ff @(posedge clk) begin
        if (lut_we && wr_ok && (state == IDLE || state == DONE))
            lut[lut_waddr] <= lut_wdata;
    end

    assign ctrl_branch = in_run && !halt_in && is_branch;
    assign take_branch = in_run && !halt_in && is_branch && branch_cond;

    always_comb begin
        target_addr = '0;
        case (state)
            LOAD:    target_addr = start_addr;
            RUN:     target_addr = rd_ok ? lut[lut_idx] : '0;
            default: target_addr = '0;
        endcase
    end

`ifdef BRANCH_CTRL_CYCLE_COUNT_EN
    logic [15:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            cnt <= '0;
        else if (launch)
            cnt <= '0;
        else if (in_run && cnt != 16'hFFFF)
            cnt <= cnt + 16'd1;
    end

    assign cycle_count = cnt;
`else
    logic unused_launch;
    assign unused_launch = launch;
    assign cycle_count   = '0;
`endif

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed self-checking bench for branch_ctrl: launch, branches, LUT write gating, halt, error and async reset.
module tb_branch_ctrl;

    logic       clk;
    logic       reset;
    logic       start;
    logic [1:0] prog_sel;
    logic       is_branch;
    logic       branch_cond;
    logic [3:0] lut_idx;
    logic       lut_we;
    logic [3:0] lut_waddr;
    logic [8:0] lut_wdata;
    logic       halt_in;
    logic       pc_reset;
    logic       ctrl_branch;
    logic       take_branch;
    logic [8:0] target_addr;
    logic       busy;
    logic       done;
    logic       err;
    logic [15:0] cycle_count;

    int total  = 0;
    int passed = 0;

`ifdef BRANCH_CTRL_CYCLE_COUNT_EN
    localparam logic [15:0] EXP10 = 16'd10;
    localparam logic [15:0] EXP1  = 16'd1;
`else
    localparam logic [15:0] EXP10 = 16'd0;
    localparam logic [15:0] EXP1  = 16'd0;
`endif

    branch_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .prog_sel    (prog_sel),
        .is_branch   (is_branch),
        .branch_cond (branch_cond),
        .lut_idx     (lut_idx),
        .lut_we      (lut_we),
        .lut_waddr   (lut_waddr),
        .lut_wdata   (lut_wdata),
        .halt_in     (halt_in),
        .pc_reset    (pc_reset),
        .ctrl_branch (ctrl_branch),
        .take_branch (take_branch),
        .target_addr (target_addr),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .cycle_count (cycle_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; prog_sel = 2'd0; is_branch = 1'b0; branch_cond = 1'b0;
        lut_idx = 4'd0; lut_we = 1'b0; lut_waddr = 4'd0; lut_wdata = 9'd0; halt_in = 1'b0;
        step(); step();
        total++;
        if ({pc_reset, ctrl_branch, take_branch, busy, done, err} !== 6'b0)
            $display("FAIL reset_flags: got %b want 000000", {pc_reset, ctrl_branch, take_branch, busy, done, err});
        else passed++;
        total++;
        if (cycle_count !== 16'd0) $display("FAIL reset_count: got %0d want 0", cycle_count);
        else passed++;
        reset = 1'b1;
    endtask

    task automatic test_err();
        start = 1'b1; prog_sel = 2'd3;
        step();
        start = 1'b0;
        total++;
        if (err !== 1'b1) $display("FAIL err_set: got %b want 1", err); else passed++;
        total++;
        if (pc_reset !== 1'b0 || busy !== 1'b0)
            $display("FAIL err_idle: got pc_reset=%b busy=%b want 0 0", pc_reset, busy);
        else passed++;
        step();
        total++;
        if (err !== 1'b0) $display("FAIL err_one_cycle: got %b want 0", err); else passed++;
    endtask

    task automatic test_lut_write();
        lut_we = 1'b1; lut_waddr = 4'd5; lut_wdata = 9'd200;
        step();
        lut_waddr = 4'd7; lut_wdata = 9'd55;
        step();
        lut_we = 1'b0;
    endtask

    task automatic test_launch();
        start = 1'b1; prog_sel = 2'd1;
        step();
        start = 1'b0;
        total++;
        if (pc_reset !== 1'b1 || target_addr !== 9'd128)
            $display("FAIL load_prog1: got pc_reset=%b target=%0d want 1 128", pc_reset, target_addr);
        else passed++;
        step();
        total++;
        if (busy !== 1'b1 || pc_reset !== 1'b0)
            $display("FAIL run_entry: got busy=%b pc_reset=%b want 1 0", busy, pc_reset);
        else passed++;
    endtask

    task automatic test_branch();
        is_branch = 1'b1; branch_cond = 1'b1; lut_idx = 4'd5;
        #1;
        total++;
        if ({ctrl_branch, take_branch} !== 2'b11 || target_addr !== 9'd200)
            $display("FAIL br_taken: got ctrl=%b take=%b target=%0d want 1 1 200", ctrl_branch, take_branch, target_addr);
        else passed++;
        branch_cond = 1'b0; lut_idx = 4'd7;
        #1;
        total++;
        if ({ctrl_branch, take_branch} !== 2'b10 || target_addr !== 9'd55)
            $display("FAIL br_not_taken: got ctrl=%b take=%b target=%0d want 1 0 55", ctrl_branch, take_branch, target_addr);
        else passed++;
        is_branch = 1'b0; branch_cond = 1'b1;
        #1;
        total++;
        if ({ctrl_branch, take_branch} !== 2'b00)
            $display("FAIL br_none: got ctrl=%b take=%b want 0 0", ctrl_branch, take_branch);
        else passed++;
    endtask

    task automatic test_run_ignores();
        lut_we = 1'b1; lut_waddr = 4'd5; lut_wdata = 9'd99;
        start = 1'b1; prog_sel = 2'd0;
        step();
        lut_we = 1'b0; start = 1'b0; lut_idx = 4'd5;
        #1;
        total++;
        if (target_addr !== 9'd200) $display("FAIL run_write_drop: got %0d want 200", target_addr);
        else passed++;
        total++;
        if (busy !== 1'b1 || pc_reset !== 1'b0)
            $display("FAIL run_start_ignored: got busy=%b pc_reset=%b want 1 0", busy, pc_reset);
        else passed++;
    endtask

    task automatic test_halt();
        is_branch = 1'b1; branch_cond = 1'b1; halt_in = 1'b1;
        #1;
        total++;
        if ({ctrl_branch, take_branch} !== 2'b00)
            $display("FAIL halt_force: got ctrl=%b take=%b want 0 0", ctrl_branch, take_branch);
        else passed++;
        step();
        halt_in = 1'b0;
        #1;
        total++;
        if (done !== 1'b1 || busy !== 1'b0 || ctrl_branch !== 1'b0)
            $display("FAIL halt_done: got done=%b busy=%b ctrl=%b want 1 0 0", done, busy, ctrl_branch);
        else passed++;
        is_branch = 1'b0;
        step();
        total++;
        if (done !== 1'b1) $display("FAIL done_hold: got %b want 1", done); else passed++;
        lut_we = 1'b1; lut_waddr = 4'd3; lut_wdata = 9'd17;
        step();
        lut_we = 1'b0;
    endtask

    task automatic test_relaunch_count();
        start = 1'b1; prog_sel = 2'd2;
        step();
        start = 1'b0;
        total++;
        if (pc_reset !== 1'b1 || target_addr !== 9'd256 || done !== 1'b0)
            $display("FAIL relaunch_load: got pc_reset=%b target=%0d done=%b want 1 256 0", pc_reset, target_addr, done);
        else passed++;
        step();
        lut_idx = 4'd5;
        #1;
        total++;
        if (target_addr !== 9'd200) $display("FAIL lut_old_kept: got %0d want 200", target_addr); else passed++;
        lut_idx = 4'd3;
        #1;
        total++;
        if (target_addr !== 9'd17) $display("FAIL lut_done_write: got %0d want 17", target_addr); else passed++;
        repeat (10) step();
        total++;
        if (cycle_count !== EXP10) $display("FAIL count_10: got %0d want %0d", cycle_count, EXP10); else passed++;
        is_branch = 1'b1; branch_cond = 1'b1;
        #1;
        reset = 1'b0;
        #2;
        total++;
        if ({pc_reset, ctrl_branch, take_branch, busy, done, err} !== 6'b0 || cycle_count !== 16'd0)
            $display("FAIL async_reset: got flags=%b count=%0d want 000000 0",
                     {pc_reset, ctrl_branch, take_branch, busy, done, err}, cycle_count);
        else passed++;
        is_branch = 1'b0; branch_cond = 1'b0;
        step();
        reset = 1'b1;
        start = 1'b1; prog_sel = 2'd0;
        step();
        start = 1'b0;
        total++;
        if (pc_reset !== 1'b1 || target_addr !== 9'd0)
            $display("FAIL load_prog0: got pc_reset=%b target=%0d want 1 0", pc_reset, target_addr);
        else passed++;
        step();
        total++;
        if (cycle_count !== 16'd0) $display("FAIL count_restart: got %0d want 0", cycle_count); else passed++;
        step();
        total++;
        if (cycle_count !== EXP1) $display("FAIL count_first: got %0d want %0d", cycle_count, EXP1); else passed++;
    endtask

    initial begin
        test_reset();
        test_err();
        test_lut_write();
        test_launch();
        test_branch();
        test_run_ignores();
        test_halt();
        test_relaunch_count();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
